// File: rtl/mips_execute_stage.sv
// rtl/mips_execute_stage.sv - EX stage of the 5-stage MIPS pipeline: ALU, target, dest reg, EX/MEM latch.
// Optional EXECUTE_OVERFLOW_EN adds o_overflow and suppresses RegWrite on signed ADD/SUB overflow.
module mips_execute_stage #(
    parameter int LEN                  = 32,
    parameter int NB_ALU_CONTROL       = 4,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 3,
    parameter int NB_CTRL_EX           = 7
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [LEN-1:0]                  i_adder_id,
    input  logic [LEN-1:0]                  i_dato1,
    input  logic [LEN-1:0]                  i_dato2,
    input  logic [LEN-1:0]                  i_sign_extend,
    input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
    input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
    input  logic [NB_CTRL_EX-1:0]           i_ctrl_ex,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_rd,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_rt,
    output logic                            o_alu_zero,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
    output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
    output logic [NB_CTRL_MEM-1:0]          o_ctrl_mem,
    output logic [LEN-1:0]                  o_add_execute,
    output logic [LEN-1:0]                  o_alu_result,
    output logic [LEN-1:0]                  o_dato2
`ifdef EXECUTE_OVERFLOW_EN
    ,
    output logic                            o_overflow
`endif
);

    localparam logic [NB_ALU_CONTROL-1:0] ALU_AND  = 4'b0000;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_OR   = 4'b0001;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_ADD  = 4'b0010;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_XOR  = 4'b0011;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_NOR  = 4'b0100;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SLT  = 4'b0101;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SUB  = 4'b0110;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SLL  = 4'b0111;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SRL  = 4'b1000;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SRA  = 4'b1001;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SLLV = 4'b1010;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SRLV = 4'b1011;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SRAV = 4'b1100;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_LUI  = 4'b1101;
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SLTU = 4'b1110;

    logic                      w_reg_dst;
    logic                      w_alu_src;
    logic                      w_jump;
    logic [NB_ALU_CONTROL-1:0] w_alu_code;
    logic [LEN-1:0]            w_op_a;
    logic [LEN-1:0]            w_op_b;
    logic [4:0]                w_shamt;
    logic [4:0]                w_shvar;
    logic [LEN-1:0]            w_sum;
    logic [LEN-1:0]            w_diff;
    logic [LEN-1:0]            w_alu_result;
    logic [LEN-1:0]            w_target;
    logic [NB_ADDRESS_REGISTROS-1:0] w_write_reg;
    logic [NB_CTRL_WB-1:0]     w_ctrl_wb;

    assign w_reg_dst  = i_ctrl_ex[6];
    assign w_alu_src  = i_ctrl_ex[5];
    assign w_jump     = i_ctrl_ex[4];
    assign w_alu_code = i_ctrl_ex[NB_ALU_CONTROL-1:0];

    assign w_op_a  = i_dato1;
    assign w_op_b  = w_alu_src ? i_sign_extend : i_dato2;
    assign w_shamt = i_sign_extend[10:6];
    assign w_shvar = w_op_a[4:0];
    assign w_sum   = w_op_a + w_op_b;
    assign w_diff  = w_op_a - w_op_b;

    always_comb begin
        w_alu_result = w_op_b;
        case (w_alu_code)
            ALU_AND:  w_alu_result = w_op_a & w_op_b;
            ALU_OR:   w_alu_result = w_op_a | w_op_b;
            ALU_ADD:  w_alu_result = w_sum;
            ALU_XOR:  w_alu_result = w_op_a ^ w_op_b;
            ALU_NOR:  w_alu_result = ~(w_op_a | w_op_b);
            ALU_SLT:  w_alu_result = {{(LEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            ALU_SUB:  w_alu_result = w_diff;
            ALU_SLL:  w_alu_result = w_op_b << w_shamt;
            ALU_SRL:  w_alu_result = w_op_b >> w_shamt;
            ALU_SRA:  w_alu_result = $signed(w_op_b) >>> w_shamt;
            ALU_SLLV: w_alu_result = w_op_b << w_shvar;
            ALU_SRLV: w_alu_result = w_op_b >> w_shvar;
            ALU_SRAV: w_alu_result = $signed(w_op_b) >>> w_shvar;
            ALU_LUI:  w_alu_result = w_op_b << 16;
            ALU_SLTU: w_alu_result = {{(LEN-1){1'b0}}, (w_op_a < w_op_b)};
            default:  w_alu_result = w_op_b;
        endcase
    end

    // Register jumps take the target from rs; otherwise a word-scaled PC-relative branch.
    assign w_target    = w_jump ? i_dato1 : (i_adder_id + (i_sign_extend << 2));
    assign w_write_reg = w_reg_dst ? i_rd : i_rt;

`ifdef EXECUTE_OVERFLOW_EN
    logic w_overflow;

    always_comb begin
        w_overflow = 1'b0;
        if (w_alu_code == ALU_ADD)
            w_overflow = (w_op_a[LEN-1] == w_op_b[LEN-1]) && (w_sum[LEN-1] != w_op_a[LEN-1]);
        else if (w_alu_code == ALU_SUB)
            w_overflow = (w_op_a[LEN-1] != w_op_b[LEN-1]) && (w_diff[LEN-1] != w_op_a[LEN-1]);
    end

    // An overflowing ADD/SUB must not update the register file.
    always_comb begin
        w_ctrl_wb    = i_ctrl_wb;
        w_ctrl_wb[1] = i_ctrl_wb[1] & ~w_overflow;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) o_overflow <= 1'b0;
        else        o_overflow <= w_overflow;
    end
`else
    assign w_ctrl_wb = i_ctrl_wb;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_alu_zero    <= 1'b0;
            o_write_reg   <= '0;
            o_ctrl_wb     <= '0;
            o_ctrl_mem    <= '0;
            o_add_execute <= '0;
            o_alu_result  <= '0;
            o_dato2       <= '0;
        end else begin
            o_alu_zero    <= (w_alu_result == '0);
            o_write_reg   <= w_write_reg;
            o_ctrl_wb     <= w_ctrl_wb;
            o_ctrl_mem    <= i_ctrl_mem;
            o_add_execute <= w_target;
            o_alu_result  <= w_alu_result;
            o_dato2       <= i_dato2;
        end
    end

endmodule

// File: tb/tb_mips_execute_stage.sv
// tb/tb_mips_execute_stage.sv - directed-vector self-checking bench for mips_execute_stage.
module tb_mips_execute_stage;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_adder_id;
    logic [31:0] i_dato1;
    logic [31:0] i_dato2;
    logic [31:0] i_sign_extend;
    logic [1:0]  i_ctrl_wb;
    logic [2:0]  i_ctrl_mem;
    logic [6:0]  i_ctrl_ex;
    logic [4:0]  i_rd;
    logic [4:0]  i_rt;
    logic        o_alu_zero;
    logic [4:0]  o_write_reg;
    logic [1:0]  o_ctrl_wb;
    logic [2:0]  o_ctrl_mem;
    logic [31:0] o_add_execute;
    logic [31:0] o_alu_result;
    logic [31:0] o_dato2;
`ifdef EXECUTE_OVERFLOW_EN
    logic        o_overflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mips_execute_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_adder_id(i_adder_id),
        .i_dato1(i_dato1), .i_dato2(i_dato2), .i_sign_extend(i_sign_extend),
        .i_ctrl_wb(i_ctrl_wb), .i_ctrl_mem(i_ctrl_mem), .i_ctrl_ex(i_ctrl_ex),
        .i_rd(i_rd), .i_rt(i_rt),
        .o_alu_zero(o_alu_zero), .o_write_reg(o_write_reg), .o_ctrl_wb(o_ctrl_wb),
        .o_ctrl_mem(o_ctrl_mem), .o_add_execute(o_add_execute),
        .o_alu_result(o_alu_result), .o_dato2(o_dato2)
`ifdef EXECUTE_OVERFLOW_EN
        , .o_overflow(o_overflow)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ctrl_ex = {RegDst, ALUSrc, Jump, alu_code}
    task automatic drive(input logic [6:0] ex, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] se);
        @(negedge i_clk);
        i_ctrl_ex     = ex;
        i_dato1       = d1;
        i_dato2       = d2;
        i_sign_extend = se;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res"},  o_alu_result, 32'h0);
        check({tag, "_zero"}, {31'h0, o_alu_zero}, 32'h0);
        check({tag, "_tgt"},  o_add_execute, 32'h0);
        check({tag, "_d2"},   o_dato2, 32'h0);
        check({tag, "_wreg"}, {27'h0, o_write_reg}, 32'h0);
        check({tag, "_wb"},   {30'h0, o_ctrl_wb}, 32'h0);
        check({tag, "_mem"},  {29'h0, o_ctrl_mem}, 32'h0);
    endtask

    initial begin
        i_rst = 1'b0;
        i_adder_id = 32'h100; i_dato1 = 32'h5; i_dato2 = 32'h7; i_sign_extend = 32'h0;
        i_ctrl_wb = 2'b11; i_ctrl_mem = 3'b111; i_ctrl_ex = 7'b1000010; i_rd = 5'd9; i_rt = 5'd3;

        repeat (3) step();
        check_all_zero("rst");

        // Release reset; first edge captures ADD 5+7
        @(negedge i_clk);
        i_rst = 1'b1;
        step();
        check("add_res", o_alu_result, 32'd12);
        check("add_zero", {31'h0, o_alu_zero}, 32'h0);
        check("add_tgt", o_add_execute, 32'h100);
        check("add_wreg", {27'h0, o_write_reg}, 32'd9);
`ifdef EXECUTE_OVERFLOW_EN
        check("add_ovf", {31'h0, o_overflow}, 32'h0);
        check("add_wb", {30'h0, o_ctrl_wb}, 32'h3);
`endif

        drive(7'b0000110, 32'd7, 32'd7, 32'h0); step();
        check("sub_res", o_alu_result, 32'h0);
        check("sub_zero", {31'h0, o_alu_zero}, 32'h1);
        check("sub_wreg", {27'h0, o_write_reg}, 32'd3);

        drive(7'b0101101, 32'h0, 32'h0, 32'h00001234); step();
        check("lui_res", o_alu_result, 32'h12340000);

        drive(7'b0001001, 32'h0, 32'h80000000, 32'h00000100); step();
        check("sra_res", o_alu_result, 32'hF8000000);
        check("sra_tgt", o_add_execute, 32'h00000500);

        drive(7'b0001011, 32'h4, 32'h80000000, 32'h0); step();
        check("srlv_res", o_alu_result, 32'h08000000);

        drive(7'b0000111, 32'h0, 32'h00000003, 32'h000000C0); step();
        check("sll_res", o_alu_result, 32'h00000018);

        drive(7'b0000100, 32'h0, 32'h0, 32'h0); step();
        check("nor_res", o_alu_result, 32'hFFFFFFFF);

        drive(7'b0000010, 32'h0, 32'h0, 32'hFFFFFFFF); step();
        check("br_tgt", o_add_execute, 32'h000000FC);

        drive(7'b0010010, 32'h400, 32'h0, 32'hFFFFFFFF); step();
        check("jr_tgt", o_add_execute, 32'h00000400);

        drive(7'b0000101, 32'hFFFFFFFF, 32'h1, 32'h0); step();
        check("slt_res", o_alu_result, 32'h1);
        drive(7'b0001110, 32'hFFFFFFFF, 32'h1, 32'h0); step();
        check("sltu_res", o_alu_result, 32'h0);
        check("sltu_zero", {31'h0, o_alu_zero}, 32'h1);

        drive(7'b1000000, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0);
        i_ctrl_wb = 2'b10; i_ctrl_mem = 3'b101;
        step();
        check("pt_d2", o_dato2, 32'hDEADBEEF);
        check("pt_wb", {30'h0, o_ctrl_wb}, 32'h2);
        check("pt_mem", {29'h0, o_ctrl_mem}, 32'h5);
        check("pt_res", o_alu_result, 32'hDEADBEEF);
        check("pt_wreg", {27'h0, o_write_reg}, 32'd9);

`ifdef EXECUTE_OVERFLOW_EN
        i_ctrl_wb = 2'b11;
        drive(7'b0000010, 32'h7FFFFFFF, 32'h1, 32'h0); step();
        check("ovf_flag", {31'h0, o_overflow}, 32'h1);
        check("ovf_wb", {30'h0, o_ctrl_wb}, 32'h1);
        check("ovf_res", o_alu_result, 32'h80000000);
        drive(7'b0000110, 32'h80000000, 32'h1, 32'h0); step();
        check("ovf_sub", {31'h0, o_overflow}, 32'h1);
`endif

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        drive(7'b0000010, 32'h1, 32'h2, 32'h0); step();
        check("pre_mid_res", o_alu_result, 32'h3);
        #2 i_rst = 1'b0;
        #1;
        check_all_zero("mid");
        @(negedge i_clk);
        i_rst = 1'b1;
        step();
        check("post_mid_res", o_alu_result, 32'h3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
